ltpi_i2c_event_tx_stage: RTL and testbench

- Sits directly downstream of the SMBus management block.
- Consumes the per-channel 4-bit I2C event codes that block produces (6 channels × 4 bits) and holds each new event until the operational-frame encoder accepts it.
- Presents the encoder a 24-bit I2C field with a valid/ready handshake, so no event is lost or duplicated between frame slots.
- Flushes all pending state when the link leaves the operational state.

---
 rtl/ltpi_i2c_event_tx_stage_pkg.sv | 25 ++
 rtl/ltpi_i2c_event_tx_stage_if.sv | 13 +
 rtl/ltpi_i2c_event_tx_stage_chan.sv | 48 ++++
 rtl/ltpi_i2c_event_tx_stage.sv | 139 +++++++++++++
 tb/tb_ltpi_i2c_event_tx_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/ltpi_i2c_event_tx_stage_pkg.sv
// Shared types for the LTPI I2C event path: event code, six-channel event
// array, the flush/run state enum and a small popcount helper.
package ltpi_pkg;

  typedef logic [3:0] i2c_evt_t;
  typedef i2c_evt_t [5:0] i2c_evt_arr_t;

  localparam i2c_evt_t I2C_EVT_IDLE = 4'h0;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } evt_fsm_t;

  // Number of set bits in a six-bit channel vector (0..6).
  function automatic logic [2:0] count_ones(input logic [5:0] vec);
    logic [2:0] num;
    num = '0;
    for (int i = 0; i < 6; i++) begin
      num = num + {2'b00, vec[i]};
    end
    return num;
  endfunction

endpackage

// File: rtl/ltpi_i2c_event_tx_stage_if.sv
// Valid/ready handshake carrying the 24-bit I2C field towards the
// operational-frame encoder. master = this stage, slave = the encoder.
interface ltpi_i2c_event_tx_stage_if;
  import ltpi_pkg::*;

  logic         fld_valid;
  logic         fld_ready;
  i2c_evt_arr_t fld_data;

  modport master (output fld_valid, output fld_data, input fld_ready);
  modport slave  (input fld_valid, input fld_data, output fld_ready);

endinterface

// File: rtl/ltpi_i2c_event_tx_stage_chan.sv
// One I2C channel: edge detector on the incoming event code, a one-deep
// pending slot that the encoder drains, and an overflow pulse when a newer
// event overwrites a code that has not been taken yet.
module ltpi_i2c_evt_chan
  import ltpi_pkg::*;
#(
  parameter bit       ENABLE    = 1'b1,
  parameter i2c_evt_t IDLE_CODE = I2C_EVT_IDLE
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     capture_en,
  input  logic     xfer,
  input  i2c_evt_t evt_in,
  output logic     pending,
  output i2c_evt_t code,
  output logic     ovf
);

  i2c_evt_t prev;
  logic     new_evt;

  assign new_evt = ENABLE && capture_en && (evt_in != prev) && (evt_in != IDLE_CODE);
  assign ovf     = new_evt && pending && !xfer;

  // Track the input every cycle; a new event loads the slot even when the
  // encoder drains it in the same cycle, so loading wins over clearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev    <= IDLE_CODE;
      pending <= 1'b0;
      code    <= IDLE_CODE;
    end else begin
      prev <= evt_in;
      if (!capture_en) begin
        pending <= 1'b0;
        code    <= IDLE_CODE;
      end else if (new_evt) begin
        pending <= 1'b1;
        code    <= evt_in;
      end else if (xfer) begin
        pending <= 1'b0;
        code    <= IDLE_CODE;
      end
    end
  end

endmodule

// File: rtl/ltpi_i2c_event_tx_stage.sv
// I2C event transmit stage between SMBus management and the operational
// frame encoder. Holds per-channel events until the encoder takes them,
// flushes whenever the link is not operational, and keeps overflow counts.
// Optional statistics (per-channel transfer counts, longest stall) are
// built when LTPI_I2C_EVT_STATS_EN is defined.
module ltpi_i2c_event_tx_stage
  import ltpi_pkg::*;
#(
  parameter int               NUM_CH    = 6,
  parameter int               EVT_W     = 4,
  parameter logic [EVT_W-1:0] IDLE_CODE = 4'h0,
  parameter int               CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  link_operational,
  input  i2c_evt_arr_t          i2c_event_in,
  ltpi_i2c_event_tx_stage_if.master fld,
  output logic [5:0]            ovf_flag,
  input  logic                  ovf_clr,
  output logic [CNT_W-1:0]      ovf_cnt
`ifdef LTPI_I2C_EVT_STATS_EN
  ,
  output logic [5:0][CNT_W-1:0] evt_cnt,
  output logic [CNT_W-1:0]      max_wait
`endif
);

  evt_fsm_t     state, state_next;
  logic         capture_en;
  logic         xfer;
  logic [5:0]   pending;
  logic [5:0]   ovf_vec;
  i2c_evt_arr_t code_arr;
  i2c_evt_arr_t data_int;
  logic [2:0]   ovf_num;
  logic [CNT_W:0] ovf_sum;

  // State register: FLUSH out of reset, otherwise follows link state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FLUSH;
    else          state <= state_next;
  end

  // Next state; capture only in RUN while the link is still up, so a link
  // drop clears all pending slots at the coming edge.
  always_comb begin
    state_next = state;
    capture_en = 1'b0;
    case (state)
      FLUSH: if (link_operational) state_next = RUN;
      RUN: begin
        capture_en = link_operational;
        if (!link_operational) state_next = FLUSH;
      end
      default: state_next = FLUSH;
    endcase
  end

  for (genvar ch = 0; ch < 6; ch++) begin : g_ch
    ltpi_i2c_evt_chan #(
      .ENABLE    (ch < NUM_CH),
      .IDLE_CODE (IDLE_CODE)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .capture_en (capture_en),
      .xfer       (xfer),
      .evt_in     (i2c_event_in[ch]),
      .pending    (pending[ch]),
      .code       (code_arr[ch]),
      .ovf        (ovf_vec[ch])
    );
  end

  // Field presented to the encoder: pending codes, idle for empty slots.
  always_comb begin
    data_int = '0;
    for (int i = 0; i < 6; i++) begin
      data_int[i] = pending[i] ? code_arr[i] : IDLE_CODE;
    end
  end

  assign fld.fld_data  = data_int;
  assign fld.fld_valid = (state == RUN) && (|pending);
  assign xfer          = fld.fld_valid && fld.fld_ready;

  assign ovf_num = count_ones(ovf_vec);
  assign ovf_sum = {1'b0, ovf_cnt} + {{(CNT_W-2){1'b0}}, ovf_num};

  // Sticky overflow flags and saturating total; clear beats a new overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_flag <= '0;
      ovf_cnt  <= '0;
    end else if (ovf_clr) begin
      ovf_flag <= '0;
      ovf_cnt  <= '0;
    end else begin
      ovf_flag <= ovf_flag | ovf_vec;
      ovf_cnt  <= ovf_sum[CNT_W] ? {CNT_W{1'b1}} : ovf_sum[CNT_W-1:0];
    end
  end

`ifdef LTPI_I2C_EVT_STATS_EN
  logic [CNT_W-1:0] wait_cur;
  logic [CNT_W-1:0] wait_inc;

  assign wait_inc = (wait_cur == {CNT_W{1'b1}}) ? wait_cur : wait_cur + CNT_W'(1);

  // Per-channel count of codes handed to the encoder, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_cnt <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (ovf_clr)
          evt_cnt[i] <= '0;
        else if (xfer && pending[i] && (evt_cnt[i] != {CNT_W{1'b1}}))
          evt_cnt[i] <= evt_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Longest run of stalled cycles (valid high, ready low) seen so far.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cur <= '0;
      max_wait <= '0;
    end else if (fld.fld_valid && !fld.fld_ready) begin
      wait_cur <= wait_inc;
      if (wait_inc > max_wait) max_wait <= wait_inc;
    end else begin
      wait_cur <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_ltpi_i2c_event_tx_stage.sv
// Directed bench for ltpi_i2c_event_tx_stage: expected outputs are queued
// as each step is driven and popped when the step's result is sampled.
module tb_ltpi_i2c_event_tx_stage;
  import ltpi_pkg::*;

  typedef struct {
    string        tag;
    logic         v;
    i2c_evt_arr_t d;
    logic [5:0]   f;
    logic [15:0]  c;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         link_operational;
  i2c_evt_arr_t i2c_event_in;
  logic [5:0]   ovf_flag;
  logic         ovf_clr;
  logic [15:0]  ovf_cnt;
`ifdef LTPI_I2C_EVT_STATS_EN
  logic [5:0][15:0] evt_cnt;
  logic [15:0]      max_wait;
`endif

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  ltpi_i2c_event_tx_stage_if fld_if ();

  ltpi_i2c_event_tx_stage dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .link_operational (link_operational),
    .i2c_event_in     (i2c_event_in),
    .fld              (fld_if),
    .ovf_flag         (ovf_flag),
    .ovf_clr          (ovf_clr),
    .ovf_cnt          (ovf_cnt)
`ifdef LTPI_I2C_EVT_STATS_EN
    ,
    .evt_cnt          (evt_cnt),
    .max_wait         (max_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic i2c_evt_arr_t arr1(input int ch, input i2c_evt_t c);
    i2c_evt_arr_t a;
    a = '0;
    a[ch] = c;
    return a;
  endfunction

  function automatic i2c_evt_arr_t fill(input i2c_evt_t c);
    i2c_evt_arr_t a;
    for (int i = 0; i < 6; i++) a[i] = c;
    return a;
  endfunction

  task automatic applyStimulus(input string tag, input i2c_evt_arr_t in, input logic rdy,
                               input logic lnk, input logic clr, input logic ev,
                               input i2c_evt_arr_t ed, input logic [5:0] ef,
                               input logic [15:0] ec);
    exp_t e;
    i2c_event_in       = in;
    fld_if.fld_ready   = rdy;
    link_operational   = lnk;
    ovf_clr            = clr;
    e.tag = tag; e.v = ev; e.d = ed; e.f = ef; e.c = ec;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    n_vec++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=nonzero");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      assert (fld_if.fld_valid === e.v) else begin
        n_err++;
        $error("[TB] FAIL %s.valid observed=%b expected=%b", e.tag, fld_if.fld_valid, e.v);
      end
      n_vec++;
      assert (fld_if.fld_data === e.d) else begin
        n_err++;
        $error("[TB] FAIL %s.data observed=%h expected=%h", e.tag, fld_if.fld_data, e.d);
      end
      n_vec++;
      assert (ovf_flag === e.f) else begin
        n_err++;
        $error("[TB] FAIL %s.ovf_flag observed=%b expected=%b", e.tag, ovf_flag, e.f);
      end
      n_vec++;
      assert (ovf_cnt === e.c) else begin
        n_err++;
        $error("[TB] FAIL %s.ovf_cnt observed=%h expected=%h", e.tag, ovf_cnt, e.c);
      end
    end
  endtask

  task automatic step(input string tag, input i2c_evt_arr_t in, input logic rdy,
                      input logic lnk, input logic clr, input logic ev,
                      input i2c_evt_arr_t ed, input logic [5:0] ef, input logic [15:0] ec);
    applyStimulus(tag, in, rdy, lnk, clr, ev, ed, ef, ec);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    reset_n          = 1'b0;
    i2c_event_in     = '0;
    fld_if.fld_ready = 1'b0;
    link_operational = 1'b1;
    ovf_clr          = 1'b0;
    @(negedge clk);
    applyStimulus("reset", '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 6'h00, 16'h0000);
    checkOutput();
    reset_n = 1'b1;
    step("boot", '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 6'h00, 16'h0000);

    // Single event, stalled then taken
    step("ch2_evt",  arr1(2, 4'h3), 1'b0, 1'b1, 1'b0, 1'b1, arr1(2, 4'h3), 6'h00, 16'h0000);
    step("ch2_xfer", arr1(2, 4'h3), 1'b1, 1'b1, 1'b0, 1'b0, '0,            6'h00, 16'h0000);
    step("ch2_idle", '0,            1'b0, 1'b1, 1'b0, 1'b0, '0,            6'h00, 16'h0000);

    // Overflow on ch0, then clear
    step("ch0_evt",  arr1(0, 4'h5), 1'b0, 1'b1, 1'b0, 1'b1, arr1(0, 4'h5), 6'h00, 16'h0000);
    step("ch0_ovf",  arr1(0, 4'h6), 1'b0, 1'b1, 1'b0, 1'b1, arr1(0, 4'h6), 6'h01, 16'h0001);
    step("ch0_clr",  arr1(0, 4'h6), 1'b0, 1'b1, 1'b1, 1'b1, arr1(0, 4'h6), 6'h00, 16'h0000);
    step("ch0_xfer", arr1(0, 4'h6), 1'b1, 1'b1, 1'b0, 1'b0, '0,            6'h00, 16'h0000);
    step("ch0_idle", '0,            1'b0, 1'b1, 1'b0, 1'b0, '0,            6'h00, 16'h0000);

    // New event in the transfer cycle is loaded, not lost
    step("ch1_evt",  arr1(1, 4'h2), 1'b0, 1'b1, 1'b0, 1'b1, arr1(1, 4'h2), 6'h00, 16'h0000);
    step("ch1_load", arr1(1, 4'h7), 1'b1, 1'b1, 1'b0, 1'b1, arr1(1, 4'h7), 6'h00, 16'h0000);
    step("ch1_xfer", arr1(1, 4'h7), 1'b1, 1'b1, 1'b0, 1'b0, '0,            6'h00, 16'h0000);
    step("ch1_idle", '0,            1'b0, 1'b1, 1'b0, 1'b0, '0,            6'h00, 16'h0000);

    // Link drop flushes; return with unchanged input captures nothing
    step("ch34_evt",  arr1(3, 4'h9) | arr1(4, 4'hA), 1'b0, 1'b1, 1'b0, 1'b1,
         arr1(3, 4'h9) | arr1(4, 4'hA), 6'h00, 16'h0000);
    step("link_drop", arr1(3, 4'h9) | arr1(4, 4'hA), 1'b0, 1'b0, 1'b0, 1'b0, '0, 6'h00, 16'h0000);
    step("link_down", arr1(3, 4'h9) | arr1(4, 4'hA), 1'b0, 1'b0, 1'b0, 1'b0, '0, 6'h00, 16'h0000);
    step("link_up0",  arr1(3, 4'h9) | arr1(4, 4'hA), 1'b0, 1'b1, 1'b0, 1'b0, '0, 6'h00, 16'h0000);
    step("link_up1",  arr1(3, 4'h9) | arr1(4, 4'hA), 1'b0, 1'b1, 1'b0, 1'b0, '0, 6'h00, 16'h0000);
    step("link_idle", '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, 6'h00, 16'h0000);

    // All six channels overflow together until the counter saturates
    step("sat_load", fill(4'h1), 1'b0, 1'b1, 1'b0, 1'b1, fill(4'h1), 6'h00, 16'h0000);
    for (int i = 1; i <= 10922; i++) begin
      i2c_event_in = fill((i % 2 == 1) ? 4'h2 : 4'h1);
      @(posedge clk);
      @(negedge clk);
    end
    step("sat_near", fill(4'h1), 1'b0, 1'b1, 1'b0, 1'b1, fill(4'h1), 6'h3F, 16'hFFFC);
    step("sat_hit",  fill(4'h2), 1'b0, 1'b1, 1'b0, 1'b1, fill(4'h2), 6'h3F, 16'hFFFF);
    step("sat_hold", fill(4'h1), 1'b0, 1'b1, 1'b0, 1'b1, fill(4'h1), 6'h3F, 16'hFFFF);
    step("sat_clr",  fill(4'h1), 1'b1, 1'b1, 1'b1, 1'b0, '0,         6'h00, 16'h0000);
    step("sat_idle", '0,         1'b0, 1'b1, 1'b0, 1'b0, '0,         6'h00, 16'h0000);

    // Asynchronous reset in the middle of a handshake
    step("ch5_evt", arr1(5, 4'h4), 1'b0, 1'b1, 1'b0, 1'b1, arr1(5, 4'h4), 6'h00, 16'h0000);
    fld_if.fld_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    applyStimulus("async_rst", arr1(5, 4'h4), 1'b1, 1'b1, 1'b0, 1'b0, '0, 6'h00, 16'h0000);
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rst0", arr1(5, 4'h4), 1'b0, 1'b1, 1'b0, 1'b0, '0, 6'h00, 16'h0000);
    step("post_rst1", arr1(5, 4'h4), 1'b0, 1'b1, 1'b0, 1'b0, '0, 6'h00, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
